// File: rtl/uart_byte_receiver.sv
// ============================================================================
// Module      : uart_byte_receiver
// Description : UART 8N1 receiver with 3-sample majority voting, valid/ready
//               holding register and sticky overrun/frame error flags.
//               Define UART_RX_PARITY_EN to receive 8E1 (even parity) frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ready,
    input  logic       rx_err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_MID_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_MID    = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_CW-1:0] c_MID_P1 = c_CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
    localparam logic [2:0] c_ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd5;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    logic [2:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_bad;
    logic                   r_busy;
    logic                   r_deliver;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic w_rxs;
    logic w_maj;
    logic w_at_decide;
    logic w_bit_end;
    logic w_frame_evt;

    assign w_rxs       = r_sync[SYNC_STAGES-1];
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_at_decide = (r_cnt == c_MID_P1);
    assign w_bit_end   = (r_cnt == c_LAST);
    assign w_frame_evt = (r_state == c_ST_STOP) && w_at_decide && (!w_maj || r_bad);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_rxs_d   <= 1'b1;
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_bad     <= 1'b0;
            r_busy    <= 1'b0;
            r_deliver <= 1'b0;
        end else begin
            r_rxs_d   <= w_rxs;
            r_deliver <= 1'b0;
            if (r_cnt == c_MID_M1) r_s0 <= w_rxs;
            if (r_cnt == c_MID)    r_s1 <= w_rxs;
            // Counter only runs while a frame is in progress.
            if (r_state == c_ST_IDLE || r_state == c_ST_BREAK)
                r_cnt <= '0;
            else
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (r_rxs_d && !w_rxs) begin
                        r_state <= c_ST_START;
                        r_bad   <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_at_decide) begin
                        if (w_maj) r_state <= c_ST_IDLE;
                        else       r_busy  <= 1'b1;
                    end else if (w_bit_end) begin
                        r_state   <= c_ST_DATA;
                        r_bit_idx <= 3'd0;
                    end
                end
                c_ST_DATA: begin
                    if (w_at_decide) r_shift <= {w_maj, r_shift[7:1]};
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_ST_PARITY;
`else
                            r_state <= c_ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_at_decide) r_bad <= (^r_shift) ^ w_maj;
                    if (w_bit_end)   r_state <= c_ST_STOP;
                end
`endif
                c_ST_STOP: begin
                    // Leave at the decision point so a start edge inside the stop bit is seen.
                    if (w_at_decide) begin
                        r_busy <= 1'b0;
                        if (!w_maj) begin
                            r_state <= c_ST_BREAK;
                        end else begin
                            r_state   <= c_ST_IDLE;
                            r_deliver <= !r_bad;
                        end
                    end
                end
                c_ST_BREAK: begin
                    if (w_rxs) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            // Clear first so a simultaneous new error leaves the flag set.
            if (rx_err_clr) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (r_deliver && r_valid && !rx_ready) r_overrun <= 1'b1;
            if (w_frame_evt) r_frame_err <= 1'b1;
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_busy      = r_busy;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_receiver.sv
// ============================================================================
// Module      : tb_uart_byte_receiver
// Description : Directed self-checking bench for uart_byte_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_byte_receiver;

    localparam int CPB = 16;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       rxd    = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks   = 0;
    int failures = 0;

    int   vhigh = 0;
    int   brise = 0;
    int   frise = 0;
    logic busy_q = 1'b0;
    logic ferr_q = 1'b0;

    int v0, b0, b1, f0;

    uart_byte_receiver #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .rxd          (rxd),
        .rx_ready     (rx_ready),
        .rx_err_clr   (rx_err_clr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #1 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (rx_valid) vhigh <= vhigh + 1;
        if (rx_busy && !busy_q) brise <= brise + 1;
        if (rx_frame_err && !ferr_q) frise <= frise + 1;
        busy_q <= rx_busy;
        ferr_q <= rx_frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (CPB) @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        bit_time(stop_v);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge sysclk);
        chk("rst_data",  rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_busy",  rx_busy, 1'b0);
        chk("rst_ovr",   rx_overrun, 1'b0);
        chk("rst_ferr",  rx_frame_err, 1'b0);
        reset = 1'b1;
        repeat (2) bit_time(1'b1);

        // Test 1: 8'h96
        send_frame(8'h96, 1'b1, 1'b0);
        chk("t1_valid", rx_valid, 1'b1);
        chk("t1_data",  rx_data, 8'h96);
        chk("t1_ovr",   rx_overrun, 1'b0);
        chk("t1_ferr",  rx_frame_err, 1'b0);
        chk("t1_busy",  rx_busy, 1'b0);

        // Test 2: back-to-back 8'hB9 without consuming -> overrun
        send_frame(8'hB9, 1'b1, 1'b0);
        chk("t2_ovr",   rx_overrun, 1'b1);
        chk("t2_data",  rx_data, 8'h96);
        chk("t2_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        @(negedge sysclk);
        rx_ready = 1'b0;
        @(negedge sysclk);
        chk("t2_consumed", rx_valid, 1'b0);

        // Test 3: ready held high -> single-cycle valid
        repeat (15) bit_time(1'b1);
        rx_ready = 1'b1;
        v0 = vhigh;
        fork
            send_frame(8'h1E, 1'b1, 1'b0);
            begin
                repeat (3 * CPB) @(negedge sysclk);
                chk("t3_busy_mid", rx_busy, 1'b1);
            end
        join
        bit_time(1'b1);
        chk("t3_pulse", vhigh - v0, 1);
        chk("t3_data",  rx_data, 8'h1E);
        chk("t3_valid", rx_valid, 1'b0);
        rx_ready = 1'b0;

        // Test 4: glitch shorter than the sampling window
        b0 = brise;
        rxd = 1'b0;
        repeat (3) @(negedge sysclk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge sysclk);
        chk("t4_busy_rise", brise - b0, 0);
        chk("t4_valid", rx_valid, 1'b0);
        chk("t4_ferr",  rx_frame_err, 1'b0);
        chk("t4_ovr_sticky", rx_overrun, 1'b1);

        // Test 5: stop bit 0 then line held low -> one frame error
        f0 = frise;
        send_frame(8'h55, 1'b0, 1'b0);
        b1 = brise;
        repeat (3) bit_time(1'b0);
        repeat (2) bit_time(1'b1);
        chk("t5_ferr", rx_frame_err, 1'b1);
        chk("t5_valid", rx_valid, 1'b0);
        chk("t5_one_err", frise - f0, 1);
        chk("t5_no_refr", brise - b1, 0);
        send_frame(8'hA5, 1'b1, 1'b0);
        bit_time(1'b1);
        chk("t5_a5_valid", rx_valid, 1'b1);
        chk("t5_a5_data",  rx_data, 8'hA5);
        rx_err_clr = 1'b1;
        @(negedge sysclk);
        rx_err_clr = 1'b0;
        chk("t5_clr_ferr", rx_frame_err, 1'b0);
        chk("t5_clr_ovr",  rx_overrun, 1'b0);
        chk("t5_clr_valid", rx_valid, 1'b1);

        // Test 6: reset mid-DATA, then 8'h3C
        bit_time(1'b0);
        bit_time(1'b1);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge sysclk);
        chk("t6_busy_pre", rx_busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", rx_valid, 1'b0);
        chk("t6_rst_data",  rx_data, 8'h00);
        chk("t6_rst_busy",  rx_busy, 1'b0);
        rxd = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        repeat (2) bit_time(1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        bit_time(1'b1);
        chk("t6_valid", rx_valid, 1'b1);
        chk("t6_data",  rx_data, 8'h3C);
        chk("t6_ferr",  rx_frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Bad parity: byte dropped, frame error flagged
        send_frame(8'h5A, 1'b1, 1'b1);
        bit_time(1'b1);
        chk("par_ferr", rx_frame_err, 1'b1);
        chk("par_data", rx_data, 8'h3C);
        chk("par_ovr",  rx_overrun, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
